// File: rtl/in_port.sv
// Debounced 8-bit input port: two-flop synchronizer, whole-byte stability counter,
// committed value readable with a sticky "changed" flag that a CPU read clears.
module in_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_lines,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       changed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    stable_q, stable_d;
  logic          changed_q, changed_d;
  logic          commit_diff;

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    commit_diff = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      // Saturated: keep re-committing the candidate; only a real change flags it.
      stable_d    = cand_q;
      commit_diff = (cand_q != stable_q);
    end
    if (commit_diff)      changed_d = 1'b1;
    else if (read_enable) changed_d = 1'b0;
    else                  changed_d = changed_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= in_lines;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign read_data = stable_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_in_port.sv
// Bench for in_port: per-cycle vector table on a DEBOUNCE_CYCLES=4 build, plus
// hand sequences for reset corners and a DEBOUNCE_CYCLES=1 build.
module tb_in_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_lines = 8'h00;
  logic       read_enable = 1'b0;
  logic [7:0] rd4, rd1;
  logic       ch4, ch1;

  int checks = 0;
  int errors = 0;

  in_port #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_lines(in_lines), .read_enable(read_enable),
    .read_data(rd4), .changed(ch4)
  );

  in_port #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_lines(in_lines), .read_enable(read_enable),
    .read_data(rd1), .changed(ch1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic       re;
    logic [7:0] d;
    logic       c;
    string      tag;
  } vec_t;

  vec_t vq[$];

  task automatic push(input logic [7:0] in, input logic re, input logic [7:0] d,
                      input logic c, input string tag, input int n = 1);
    vec_t v;
    v.in = in; v.re = re; v.d = d; v.c = c; v.tag = tag;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act_d, input logic act_c,
                     input logic [7:0] exp_d, input logic exp_c);
    checks++;
    if (act_d !== exp_d || act_c !== exp_c) begin
      errors++;
      $display("FAIL %s: read_data=%h changed=%b, expected read_data=%h changed=%b",
               name, act_d, act_c, exp_d, exp_c);
    end
  endtask

  task automatic step(input logic [7:0] in, input logic re);
    in_lines    = in;
    read_enable = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Glitch of 4 sampled edges then back to 00: never committed.
    push(8'h3C, 1'b0, 8'h00, 1'b0, "glitch_3c", 4);
    push(8'h00, 1'b0, 8'h00, 1'b0, "glitch_back", 8);
    // Basic commit: nothing through edge 6, commit on edge 7.
    push(8'hA5, 1'b0, 8'h00, 1'b0, "a5_pre", 6);
    push(8'hA5, 1'b0, 8'hA5, 1'b1, "a5_commit", 1);
    push(8'hA5, 1'b0, 8'hA5, 1'b1, "a5_saturate", 2);
    push(8'hA5, 1'b1, 8'hA5, 1'b0, "a5_read", 1);
    push(8'hA5, 1'b0, 8'hA5, 1'b0, "a5_after_read", 2);
    // Commit 5A then a single read pulse.
    push(8'h5A, 1'b0, 8'hA5, 1'b0, "5a_pre", 6);
    push(8'h5A, 1'b0, 8'h5A, 1'b1, "5a_commit", 1);
    push(8'h5A, 1'b1, 8'h5A, 1'b0, "5a_read", 1);
    push(8'h5A, 1'b0, 8'h5A, 1'b0, "5a_idle", 1);
    // Read on the commit edge: set wins; held read then clears.
    push(8'h81, 1'b0, 8'h5A, 1'b0, "81_pre", 6);
    push(8'h81, 1'b1, 8'h81, 1'b1, "81_commit_read", 1);
    push(8'h81, 1'b1, 8'h81, 1'b0, "81_read_held", 2);
    // One bit changing mid-debounce restarts the whole byte.
    push(8'h0F, 1'b0, 8'h81, 1'b0, "0f_partial", 3);
    push(8'h0E, 1'b0, 8'h81, 1'b0, "0e_pre", 6);
    push(8'h0E, 1'b0, 8'h0E, 1'b1, "0e_commit", 1);

    rst = 1'b1;
    in_lines = 8'h00;
    read_enable = 1'b0;
    #1;
    chk("reset_during", rd4, ch4, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_after", rd4, ch4, 8'h00, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].in, vq[i].re);
      chk(vq[i].tag, rd4, ch4, vq[i].d, vq[i].c);
    end

    // Reset mid-debounce with FF held: outputs drop at once, then FF commits on edge 7.
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_immediate", rd4, ch4, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(8'hFF, 1'b0);
      chk($sformatf("rst_mid_pre_%0d", e), rd4, ch4, 8'h00, 1'b0);
    end
    step(8'hFF, 1'b0);
    chk("rst_mid_commit", rd4, ch4, 8'hFF, 1'b1);

    // Release with zero inputs: no commit-induced change.
    in_lines = 8'h00;
    rst = 1'b1;
    #3;
    chk("rst_zero_during", rd4, ch4, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step(8'h00, 1'b0);
      chk($sformatf("rst_zero_%0d", e), rd4, ch4, 8'h00, 1'b0);
    end

    // DEBOUNCE_CYCLES=1 build: fresh reset, commit on edge 4, 1-edge pulse rejected.
    rst = 1'b1;
    #3;
    chk("d1_reset", rd1, ch1, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step(8'h0F, 1'b0);
      chk($sformatf("d1_pre_%0d", e), rd1, ch1, 8'h00, 1'b0);
    end
    step(8'h0F, 1'b0);
    chk("d1_commit", rd1, ch1, 8'h0F, 1'b1);
    step(8'hF0, 1'b0);
    chk("d1_pulse", rd1, ch1, 8'h0F, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      step(8'h0F, 1'b0);
      chk($sformatf("d1_pulse_after_%0d", e), rd1, ch1, 8'h0F, 1'b1);
    end
    step(8'h0F, 1'b1);
    chk("d1_read", rd1, ch1, 8'h0F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
